// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared op encodings and BCD converter state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam logic OP_INC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [0:0] {
    BCD_IDLE = 1'b0,
    BCD_BUSY = 1'b1
  } bcd_state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_datapath_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble binary-to-BCD converter, one bit/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  bcd_state_t              r_state;
  bcd_state_t              w_state_nxt;
  logic [WIDTH-1:0]        r_shift;
  logic [WIDTH-1:0]        w_shift_nxt;
  logic [4*DIGITS-1:0]     r_acc;
  logic [4*DIGITS-1:0]     w_acc_nxt;
  logic [4*DIGITS-1:0]     w_adj;
  logic [4*DIGITS-1:0]     w_step;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [4*DIGITS-1:0]     r_bcd;
  logic [4*DIGITS-1:0]     w_bcd_nxt;

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
    w_step = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
  end

  // A start always wins, so a busy conversion is abandoned and re-snapshotted.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    if (start) begin
      w_state_nxt = BCD_BUSY;
      w_shift_nxt = bin_in;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        BCD_BUSY: begin
          w_acc_nxt   = w_step;
          w_shift_nxt = r_shift << 1;
          w_cnt_nxt   = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_bcd_nxt   = w_step;
            w_state_nxt = BCD_IDLE;
          end
        end
        default: w_state_nxt = BCD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BCD_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
    end
  end

  assign bcd_out = r_bcd;
  assign valid   = (r_state == BCD_IDLE);

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/counter_datapath.sv
`default_nettype none
// ============================================================================
// Module   : counter_datapath
// Purpose  : Saturating up/down count register with status flags, sticky
//            illegal-load error and optional sequential BCD image.
// Config   : COUNTER_DP_BCD_EN enables the BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
module counter_datapath
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAX    = 99,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op,
  input  logic                  c_clr,
  input  logic                  c_ld,
  output logic                  z,
  output logic                  m,
  output logic [WIDTH-1:0]      count,
  output logic                  err,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;
  logic             r_err;
  logic             w_inc_ok;
  logic             w_dec_ok;

  // Flags decode only the register, keeping the FSM loop free of comb paths.
  assign w_inc_ok = (r_count < C_MAX);
  assign w_dec_ok = (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (c_clr) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (c_ld) begin
      if (op == OP_INC) begin
        if (w_inc_ok) r_count <= r_count + WIDTH'(1);
        else          r_err   <= 1'b1;
      end else begin
        if (w_dec_ok) r_count <= r_count - WIDTH'(1);
        else          r_err   <= 1'b1;
      end
    end
  end

  assign count = r_count;
  assign err   = r_err;
  assign z     = w_dec_ok;
  assign m     = w_inc_ok;

`ifdef COUNTER_DP_BCD_EN
  logic w_write;
  logic r_start;

  assign w_write = (c_clr && w_dec_ok) ||
                   (!c_clr && c_ld && ((op == OP_INC) ? w_inc_ok : w_dec_ok));

  always_ff @(posedge clk) begin
    if (reset) r_start <= 1'b0;
    else       r_start <= w_write;
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (r_start),
    .bin_in  (r_count),
    .bcd_out (bcd),
    .valid   (bcd_valid)
  );
`else
  assign bcd       = '0;
  assign bcd_valid = 1'b0;
`endif

endmodule : counter_datapath
`default_nettype wire
